// File: rtl/decode_ctrl_stage_pkg.sv
// Shared definitions for the decode/control stage: opcode and function
// constants, FSM state encoding and the registered control-bundle layout.
package decode_ctrl_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  // Control bundle carried from decode to execute (PC and immediate travel
  // alongside in their own XLEN-wide registers).
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       lw_en;
    logic       sw_en;
    logic       sub_en;
    logic       wr_en;
    logic       offset_en;
    logic       jalr_en;
    logic       branch_en;
    logic       mux_sel;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_stage_imm_gen.sv
// Combinational RV32 immediate generator: picks the I/S/B/U/J layout from the
// opcode and sign-extends to XLEN. R-type and unknown opcodes yield zero.
module imm_gen
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] ins;
  logic [31:0] imm32;

  assign ins = instr_i[31:0];

  // Immediate layout selected by opcode.
  always_comb begin
    imm32 = '0;
    case (ins[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {ins[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Sign-extend the 32-bit immediate to the datapath width.
  assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage between fetch and execute.
// Handshake: a transfer happens on a side when its valid and ready are both
// high at a rising clock edge; a held bundle (out_valid & ~out_ready) stays
// stable, and in_ready never depends on in_valid except through the hazard.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             lw_en,
  output logic             sw_en,
  output logic             sub_en,
  output logic             wr_en,
  output logic             offset_en,
  output logic             jalr_en,
  output logic             branch_en,
  output logic             mux_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dbg_state
);

  localparam bit         INTERLOCK = (LOAD_USE_BUBBLES > 0);
  localparam logic [1:0] BUB_INIT  = 2'(LOAD_USE_BUBBLES - 1);

  state_e           state_q;
  logic [1:0]       bub_q;
  logic             valid_q;
  ctrl_t            ctrl_q;
  ctrl_t            dec;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  imm_dec;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic             use_rs1;
  logic             use_rs2;
  logic             writes;
  logic             advance;
  logic             hazard;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm_dec)
  );

  // Decode the incoming instruction into a control bundle and source usage.
  always_comb begin
    dec       = '0;
    dec.rd    = in_instr[11:7];
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes    = 1'b0;
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC: writes = 1'b1;
      OPC_JAL: begin
        writes        = 1'b1;
        dec.offset_en = 1'b1;
      end
      OPC_JALR: begin
        writes      = 1'b1;
        dec.jalr_en = 1'b1;
        use_rs1     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch_en = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_LOAD: begin
        writes    = 1'b1;
        dec.lw_en = (in_instr[14:12] == F3_LW);
        use_rs1   = 1'b1;
      end
      OPC_STORE: begin
        dec.sw_en = (in_instr[14:12] == F3_SW);
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OPC_OP_IMM: begin
        writes  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_OP: begin
        writes     = 1'b1;
        dec.sub_en = (in_instr[14:12] == F3_SUB) && (in_instr[31:25] == F7_SUB);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.wr_en   = writes && (dec.rd != 5'd0);
    dec.mux_sel = dec.offset_en | dec.jalr_en;
  end

  // Load-use detection against the load currently held in the output regs.
  always_comb begin
    advance = ~valid_q | out_ready;
    hazard  = INTERLOCK && valid_q && ctrl_q.lw_en && (ctrl_q.rd != 5'd0) && in_valid &&
              ((use_rs1 && (dec.rs1 == ctrl_q.rd)) || (use_rs2 && (dec.rs2 == ctrl_q.rd)));
    stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
    in_ready = ~rst & (flush | ((state_q == ST_RUN) & advance & ~hazard));
  end

  // Stage FSM: RUN passes instructions, BUBBLE emits the remaining stall slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      bub_q   <= 2'd0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      stall_q <= '0;
    end else if (flush) begin
      state_q <= ST_RUN;
      bub_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (advance) begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            valid_q <= 1'b0;
            bub_q   <= BUB_INIT;
            stall_q <= stall_d;
            if (BUB_INIT != 2'd0) state_q <= ST_BUBBLE;
          end else begin
            valid_q <= in_valid;
            ctrl_q  <= dec;
            pc_q    <= in_pc;
            imm_q   <= imm_dec;
          end
        end
        ST_BUBBLE: begin
          valid_q <= 1'b0;
          stall_q <= stall_d;
          bub_q   <= bub_q - 2'd1;
          if (bub_q == 2'd1) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_imm   = imm_q;
  assign out_rd    = ctrl_q.rd;
  assign out_rs1   = ctrl_q.rs1;
  assign out_rs2   = ctrl_q.rs2;
  assign lw_en     = ctrl_q.lw_en;
  assign sw_en     = ctrl_q.sw_en;
  assign sub_en    = ctrl_q.sub_en;
  assign wr_en     = ctrl_q.wr_en;
  assign offset_en = ctrl_q.offset_en;
  assign jalr_en   = ctrl_q.jalr_en;
  assign branch_en = ctrl_q.branch_en;
  assign mux_sel   = ctrl_q.mux_sel;
  assign illegal   = ctrl_q.illegal;
  assign stall_cnt = stall_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: directed RV32I vectors with hand-computed
// expected bundles, a queue-based scoreboard and a B=1 companion instance.
module tb_decode_ctrl_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [31:0] I_ADD  = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_SUB  = 32'h404183B3; // sub x7,x3,x4
  localparam logic [31:0] I_ADDI = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,8
  localparam logic [31:0] I_JALR = 32'h004100E7; // jalr x1,4(x2)
  localparam logic [31:0] I_SW   = 32'h0020A423; // sw x2,8(x1)
  localparam logic [31:0] I_LUI  = 32'h12345537; // lui x10,0x12345
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3; // beq x1,x2,-4
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  // Flag order: {lw, sw, sub, wr, offset, jalr, branch, mux_sel, illegal}
  localparam logic [8:0] F_ADD  = 9'b000100000;
  localparam logic [8:0] F_SUB  = 9'b001100000;
  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_LW   = 9'b100100000;
  localparam logic [8:0] F_JAL  = 9'b000110010;
  localparam logic [8:0] F_JALR = 9'b000101010;
  localparam logic [8:0] F_SW   = 9'b010000000;
  localparam logic [8:0] F_BEQ  = 9'b000000100;
  localparam logic [8:0] F_BAD  = 9'b000000001;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (two load-use bubbles)
  logic             flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]  in_instr, in_pc, out_pc, out_imm;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic             lw_en, sw_en, sub_en, wr_en, offset_en, jalr_en, branch_en, mux_sel, illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic             dbg_state;

  decode_ctrl_stage #(.XLEN(XLEN), .LOAD_USE_BUBBLES(2), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .lw_en(lw_en), .sw_en(sw_en), .sub_en(sub_en), .wr_en(wr_en),
    .offset_en(offset_en), .jalr_en(jalr_en), .branch_en(branch_en),
    .mux_sel(mux_sel), .illegal(illegal), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Companion DUT (single load-use bubble)
  logic             b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [XLEN-1:0]  b_in_instr, b_in_pc, b_out_pc, b_out_imm;
  logic [4:0]       b_out_rd, b_out_rs1, b_out_rs2;
  logic             b_lw_en, b_sw_en, b_sub_en, b_wr_en, b_offset_en, b_jalr_en;
  logic             b_branch_en, b_mux_sel, b_illegal;
  logic [CNT_W-1:0] b_stall_cnt;
  logic             b_dbg_state;

  decode_ctrl_stage #(.XLEN(XLEN), .LOAD_USE_BUBBLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_imm(b_out_imm),
    .lw_en(b_lw_en), .sw_en(b_sw_en), .sub_en(b_sub_en), .wr_en(b_wr_en),
    .offset_en(b_offset_en), .jalr_en(b_jalr_en), .branch_en(b_branch_en),
    .mux_sel(b_mux_sel), .illegal(b_illegal), .stall_cnt(b_stall_cnt), .dbg_state(b_dbg_state)
  );

  // Scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [87:0] exp_q[$];
  logic [87:0] act_bundle;

  function automatic logic [87:0] pack(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, input logic [8:0] fl);
    return {pc, rd, rs1, rs2, imm, fl};
  endfunction

  assign act_bundle = pack(out_pc, out_rd, out_rs1, out_rs2, out_imm,
                           {lw_en, sw_en, sub_en, wr_en, offset_en, jalr_en, branch_en, mux_sel, illegal});

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bundle consumed by execute is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", act_bundle);
      end else begin
        chk("bundle", act_bundle, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic wait_accept(output int refused);
    int  n    = 0;
    bit  done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else n++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
    end
    in_valid = 1'b0;
    refused  = n;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [8:0] fl);
    int r;
    exp_q.push_back(pack(pc, rd, rs1, rs2, imm, fl));
    present(instr, pc);
    wait_accept(r);
  endtask

  initial begin
    int r;
    flush = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_bundle", act_bundle, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;

    // Single-bubble instance: lw x5 then add using x5
    b_in_valid = 1; b_in_instr = I_LW; b_in_pc = 32'h40;
    @(negedge clk) chk("b1_lw_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_instr = I_ADD; b_in_pc = 32'h44;
    @(negedge clk);
    chk("b1_hazard_ready", b_in_ready, 0);
    chk("b1_lw_out", b_out_valid && b_lw_en && (b_out_rd == 5'd5), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b1_bubble_valid", b_out_valid, 0);
    chk("b1_ready_after", b_in_ready, 1);
    chk("b1_stall", b_stall_cnt, 1);
    @(posedge clk); #1;
    b_in_valid = 0;
    @(negedge clk);
    chk("b1_add_out", {b_out_valid, b_out_rd, b_out_rs1, b_out_rs2, b_wr_en, b_out_pc},
        {1'b1, 5'd6, 5'd5, 5'd2, 1'b1, 32'h44});
    chk("b1_stall_hold", b_stall_cnt, 1);
    @(posedge clk); #1;

    // Back-to-back decode vectors
    send(I_ADD,  32'h100, 5'd6,  5'd5, 5'd2,  32'h0,        F_ADD);
    send(I_SUB,  32'h104, 5'd7,  5'd3, 5'd4,  32'h0,        F_SUB);
    send(I_ADDI, 32'h108, 5'd0,  5'd0, 5'd0,  32'h0,        F_NONE);
    send(I_LUI,  32'h10C, 5'd10, 5'd8, 5'd3,  32'h12345000, F_ADD);
    send(I_JAL,  32'h110, 5'd1,  5'd0, 5'd8,  32'h8,        F_JAL);
    send(I_JALR, 32'h114, 5'd1,  5'd2, 5'd4,  32'h4,        F_JALR);
    send(I_SW,   32'h118, 5'd8,  5'd1, 5'd2,  32'h8,        F_SW);
    send(I_BEQ,  32'h11C, 5'd29, 5'd1, 5'd2,  32'hFFFFFFFC, F_BEQ);
    send(I_BAD,  32'h120, 5'd31, 5'd31, 5'd31, 32'h0,       F_BAD);

    // Load-use with two bubbles
    send(I_LW, 32'h180, 5'd5, 5'd1, 5'd0, 32'h0, F_LW);
    exp_q.push_back(pack(32'h184, 5'd6, 5'd5, 5'd2, 32'h0, F_ADD));
    present(I_ADD, 32'h184);
    wait_accept(r);
    chk("b2_refused", r, 2);
    @(negedge clk) chk("b2_stall", stall_cnt, 2);
    @(posedge clk); #1;

    // Flush while in BUBBLE: the presented add is swallowed
    send(I_LW, 32'h200, 5'd5, 5'd1, 5'd0, 32'h0, F_LW);
    present(I_ADD, 32'h204);
    @(posedge clk); #1;
    chk("fl_state_bubble", dbg_state, 1);
    flush = 1;
    @(negedge clk) chk("fl_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_state_run", dbg_state, 0);
    chk("fl_stall", stall_cnt, 3);
    @(negedge clk) chk("fl_no_output", out_valid, 0);
    @(posedge clk); #1;

    // Load followed by an instruction that does not read x5: no bubble
    send(I_LW, 32'h240, 5'd5, 5'd1, 5'd0, 32'h0, F_LW);
    exp_q.push_back(pack(32'h244, 5'd29, 5'd1, 5'd2, 32'hFFFFFFFC, F_BEQ));
    present(I_BEQ, 32'h244);
    wait_accept(r);
    chk("nohaz_refused", r, 0);
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure: held bundle stays stable and input is refused
    out_ready = 0;
    exp_q.push_back(pack(32'h300, 5'd6, 5'd5, 5'd2, 32'h0, F_ADD));
    present(I_ADD, 32'h300);
    wait_accept(r);
    exp_q.push_back(pack(32'h304, 5'd7, 5'd3, 5'd4, 32'h0, F_SUB));
    present(I_SUB, 32'h304);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", act_bundle, pack(32'h300, 5'd6, 5'd5, 5'd2, 32'h0, F_ADD));
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_accept(r);
    repeat (2) begin @(posedge clk); #1; end

    // Asynchronous reset in the middle of a bubble sequence
    send(I_LW, 32'h400, 5'd5, 5'd1, 5'd0, 32'h0, F_LW);
    present(I_ADD, 32'h404);
    @(posedge clk); #1;
    chk("rb_state_pre", dbg_state, 1);
    #2 rst = 1'b1;
    #1;
    chk("rb_state", dbg_state, 0);
    chk("rb_stall", stall_cnt, 0);
    chk("rb_in_ready", in_ready, 0);
    in_valid = 0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while a bundle is held under backpressure
    out_ready = 0;
    present(I_JAL, 32'h500);
    wait_accept(r);
    @(negedge clk) chk("rh_valid_pre", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rh_valid", out_valid, 0);
    chk("rh_bundle", act_bundle, 0);
    @(posedge clk); #2 rst = 1'b0;
    out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered RV32I decode/control stage between fetch and execute.
- Decodes the incoming instruction into a registered control bundle: load, store, sub, write-enable, jump, branch and immediate.
- Moves instructions on a valid/ready handshake.
- Inserts a configurable number of load-use bubbles and supports a flush from branch/jump resolution.

Parameters:
- XLEN, 32, instruction/immediate/PC width (instruction fields fixed to RV32 positions).
- LOAD_USE_BUBBLES, 1, bubbles inserted on a load-use hazard (0 disables the interlock, max 3).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill the held instruction and any incoming one this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  XLEN  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute consumes the bundle
- out_pc  out  XLEN  registered PC
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per opcode, 0 for R-type)
- lw_en, sw_en, sub_en, wr_en  out  1 each  load, store, ALU subtract, register write
- offset_en  out  1  JAL
- jalr_en  out  1  JALR
- branch_en  out  1  conditional branch
- mux_sel  out  1  writeback selects PC+4 (JAL/JALR)
- illegal  out  1  unsupported opcode
- stall_cnt  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset: all outputs 0, bubble counter 0, stall_cnt 0. in_ready is combinational and equals 1 once reset is released with out_valid = 0.
- Decode, on opcode bits [6:0]:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
  - wr_en = 1 for LUI/AUIPC/JAL/JALR/LOAD/OP_IMM/OP and rd != 0.
  - sub_en = 1 only for OP with funct3 = 000 and funct7 = 0100000.
  - lw_en = LOAD with funct3 = 010; sw_en = STORE with funct3 = 010.
  - mux_sel = offset_en | jalr_en.
  - Any other opcode: illegal = 1 and all enables 0; the instruction still travels through the stage.
- rs1 is used by JALR/BRANCH/LOAD/STORE/OP_IMM/OP; rs2 is used by BRANCH/STORE/OP.
- advance = (~out_valid | out_ready).
- Hazard: out_valid & lw_en & out_rd != 0 & in_valid & (used rs1 == out_rd or used rs2 == out_rd), with LOAD_USE_BUBBLES > 0.
- States:
  - RUN:
    - in_ready = advance & ~hazard.
    - On advance: out regs take the decoded input; out_valid = in_valid.
    - On advance & hazard: out_valid = 0 (bubble), bubble counter = LOAD_USE_BUBBLES - 1, stall_cnt += 1; go to BUBBLE if the counter is non-zero.
  - BUBBLE:
    - in_ready = 0.
    - Each cycle with advance: emit a bubble, stall_cnt += 1, decrement the counter; return to RUN at 0.
- Output registers hold when advance = 0 (stable while out_valid & ~out_ready).
- flush (highest priority):
  - Next edge: out_valid = 0, state RUN, counter 0.
  - in_ready = 1 that cycle; the presented instruction is accepted and discarded.
  - stall_cnt is unchanged.
- stall_cnt saturates at all-ones.
- Async reset mid-bubble returns to RUN with counter 0 immediately.

Decomposition:
- Shared package/defs header holds:
  - opcode constants;
  - funct3/funct7 constants for LW/SW/SUB;
  - an FSM state encoding (RUN, BUBBLE);
  - the control-bundle field list.
- One sub-module, imm_gen: a combinational immediate generator keyed by opcode.

Test Plan:
- Reset, then 0x00228333 (add x6,x5,x2) with out_ready = 1 -> next cycle out_valid = 1, wr_en = 1, sub_en = 0, rd = 6, rs1 = 5, rs2 = 2, out_imm = 0.
- 0x404183B3 (sub x7,x3,x4) -> sub_en = 1, wr_en = 1. Also 0x00000013 (addi x0) -> wr_en = 0.
- 0x0000A283 (lw x5,0(x1)) then 0x00228333 back-to-back:
  - LOAD_USE_BUBBLES = 1 -> in_ready = 0 for one cycle, one bubble (out_valid = 0), stall_cnt = 1, then the add issues.
  - LOAD_USE_BUBBLES = 2 -> two bubbles, stall_cnt = 2.
- 0x008000EF (jal x1,8) -> offset_en = 1, mux_sel = 1, wr_en = 1, out_imm = 8.
- 0xFFFFFFFF -> illegal = 1, all enables 0.
- Backpressure and flush:
  - Hold out_ready = 0 for 3 cycles -> outputs stable, in_ready = 0.
  - Assert flush during a BUBBLE state -> out_valid = 0 next cycle, state RUN, stall_cnt unchanged.
  - Assert rst mid-stream -> all outputs 0 without a clock edge.
